pipeline_ctrl: RTL
==================

# pipeline_ctrl

Parametrised hazard and exception controller for the five-stage MIPS pipeline, and the successor to the current combinational control unit. It sits beside the datapath and drives PC source select, per-stage stall/flush, CP0 exception writes and branch-predictor update. New behaviour over the current unit:
- configurable source-port count and load-use bubble length
- interrupts latched across memory stalls and precise against syscall
- events never commit during a memory stall
- saturating performance counters

## Interface
Parameters:
- SRC_PORTS, 2: number of ID-stage source-register ports checked for load-use (1..3)
- LU_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..7)
- EXC_VECTOR, 32'h80000180: exception entry address
- CNT_W, 16: width of each performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_src_addr  in  5*SRC_PORTS  ID source register numbers; port i is bits [5i+4:5i]
- id_src_valid  in  SRC_PORTS  port i actually reads its register
- idex_rd_addr  in  5  destination register of the ID/EX instruction
- idex_mem_read  in  1  ID/EX instruction is a load
- id_jump, id_jr  in  1  J/JAL, JR decoded in ID
- predicted_idex_pc, target_exmem_pc  in  32  predicted vs resolved next PC
- mem_nop  in  1  EX/MEM holds a bubble
- exmem_syscall, exmem_eret  in  1  SYSCALL / ERET in EX/MEM
- cp0_intr  in  1  interrupt request (may be a one-cycle pulse)
- mem_stall  in  1  data memory not ready
- cu_pc_src  out  4  0 jump, 1 jr, 2 vector, 3 EPC, 4 branch correction, 5 PC+4
- cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall  out  1  stage hold
- cu_ifid_flush, cu_idex_flush, cu_exmem_flush  out  1  stage bubble
- cu_cp0_w_en  out  1  CP0 Cause/EPC write strobe
- cu_exec_code  out  5  0 interrupt, 8 syscall
- cu_epc  out  32  EPC value to write
- cu_vector  out  32  always EXC_VECTOR
- bpu_write_en  out  1  predictor update strobe
- perf_bmiss_cnt, perf_stall_cnt  out  CNT_W  branch-miss count, PC-stall cycle count

## Operation
- Defaults: cu_pc_src=5; all stall, flush and strobe outputs 0; cu_exec_code=0; cu_epc=0.
- branch_miss = !mem_nop && (predicted_idex_pc != target_exmem_pc).
- load_use = idex_mem_read && idex_rd_addr!=0 && any valid port address equals idex_rd_addr.
- intr_pend register: set by cp0_intr; cleared when an interrupt is taken. Define intr = cp0_intr | intr_pend.
- FSM states:
  - RUN: normal operation.
  - LU_WAIT: down-counter lu_cnt (3 bits) is nonzero.
- Priority, highest first:
  1. mem_stall: assert all four stalls and nothing else. No counter, FSM or strobe changes, except that intr_pend may set.
  2. exmem_syscall: cu_pc_src=2; all three flushes; cu_cp0_w_en=1; code 8; cu_epc=predicted_idex_pc. A concurrent interrupt stays pending.
  3. intr: as syscall but with code 0. cu_epc = target_exmem_pc if branch_miss, else predicted_idex_pc. If branch_miss, also assert bpu_write_en. Clears intr_pend.
  4. branch_miss: cu_pc_src=4; all three flushes; bpu_write_en=1.
  5. exmem_eret: cu_pc_src=3; flush IF/ID and ID/EX.
  6. load_use (RUN) or state LU_WAIT:
     - assert pc_stall and ifid_stall, plus idex_flush.
     - From RUN with LU_STALL_CYCLES>1: enter LU_WAIT with lu_cnt=LU_STALL_CYCLES-1.
     - In LU_WAIT: decrement lu_cnt; return to RUN when it reaches 0.
     - Suppresses jump and jr.
  7. id_jr: cu_pc_src=1, flush IF/ID.
  8. id_jump: cu_pc_src=0, flush IF/ID.
- Levels 2–5 force the FSM to RUN and clear lu_cnt.
- Counters saturate at all-ones:
  - perf_bmiss_cnt increments on each cycle where level 3 or 4 fires with branch_miss.
  - perf_stall_cnt increments on each cycle cu_pc_stall=1.

## Timing
- All outputs except the counters are combinational from inputs and registered state. There is no added latency.
- Registered state updates on the rising clk edge.
- Reset is asynchronous. It clears the FSM to RUN, lu_cnt=0, intr_pend=0 and both counters=0. While reset is high, outputs are forced to the defaults.
- Reset asserted in LU_WAIT or with an interrupt pending discards both.
- cu_cp0_w_en is high for exactly one cycle per exception and never during mem_stall.
- An interrupt pulse under mem_stall is taken on the first cycle mem_stall=0. If a syscall occupies that cycle, it is taken one cycle later.

## Test plan
- Load into $5, then `add` reading $5 via port 1, LU_STALL_CYCLES=2 -> pc/ifid stall and idex_flush for 2 cycles; perf_stall_cnt=2. Same sequence with $0 as destination -> no stall.
- predicted_idex_pc=0x100, target_exmem_pc=0x200, mem_nop=0 -> cu_pc_src=4, three flushes, bpu_write_en=1, perf_bmiss_cnt+1. Same with mem_nop=1 -> defaults.
- cp0_intr pulse while mem_stall=1 for 3 cycles -> only stalls. Next cycle: cu_pc_src=2, cu_cp0_w_en=1, code 0, intr_pend cleared.
- exmem_syscall and cp0_intr together -> code 8 this cycle, code 0 next cycle.
- Interrupt with branch_miss, target_exmem_pc=0x400 -> cu_epc=0x400, bpu_write_en=1. eret with branch_miss -> cu_pc_src=4.
- Reset asserted mid-LU_WAIT -> outputs immediately at defaults; after release, state is RUN and counters are 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and exception controller for the five-stage MIPS pipeline. It sits
//   beside the datapath and decides, every cycle, where the next PC comes
//   from, which pipeline registers hold or take a bubble, when CP0 records an
//   exception, and when the branch predictor is updated.
//
//   Decision priority, highest first:
//     memory stall > syscall > interrupt > branch miss > eret >
//     load-use bubble > jr > jump
//
// Parameters
//   SRC_PORTS        ID-stage source-register ports checked for load-use (1..3)
//   LU_STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   EXC_VECTOR       exception entry address
//   CNT_W            width of each performance counter
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   id_src_addr / id_src_valid      ID source registers (port i = [5i+4:5i])
//   idex_rd_addr / idex_mem_read    ID/EX destination and "is a load"
//   id_jump, id_jr                  J/JAL and JR decoded in ID
//   predicted_idex_pc               PC the pipeline fetched down
//   target_exmem_pc                 PC the resolved branch actually wants
//   mem_nop                         EX/MEM holds a bubble
//   exmem_syscall, exmem_eret       SYSCALL / ERET in EX/MEM
//   cp0_intr                        interrupt request (may be a single pulse)
//   mem_stall                       data memory not ready
//   cu_pc_src                       0 jump, 1 jr, 2 vector, 3 EPC,
//                                   4 branch correction, 5 PC+4
//   cu_*_stall / cu_*_flush         per-stage hold / bubble
//   cu_cp0_w_en, cu_exec_code,
//   cu_epc                          CP0 Cause/EPC write strobe and payload
//   cu_vector                       constant exception entry address
//   bpu_write_en                    predictor update strobe
//   perf_bmiss_cnt, perf_stall_cnt  saturating branch-miss / PC-stall counts
module pipeline_ctrl #(
  parameter int          SRC_PORTS       = 2,
  parameter int          LU_STALL_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR      = 32'h80000180,
  parameter int          CNT_W           = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5*SRC_PORTS-1:0]   id_src_addr,
  input  logic [SRC_PORTS-1:0]     id_src_valid,
  input  logic [4:0]               idex_rd_addr,
  input  logic                     idex_mem_read,
  input  logic                     id_jump,
  input  logic                     id_jr,
  input  logic [31:0]              predicted_idex_pc,
  input  logic [31:0]              target_exmem_pc,
  input  logic                     mem_nop,
  input  logic                     exmem_syscall,
  input  logic                     exmem_eret,
  input  logic                     cp0_intr,
  input  logic                     mem_stall,
  output logic [3:0]               cu_pc_src,
  output logic                     cu_pc_stall,
  output logic                     cu_ifid_stall,
  output logic                     cu_idex_stall,
  output logic                     cu_exmem_stall,
  output logic                     cu_ifid_flush,
  output logic                     cu_idex_flush,
  output logic                     cu_exmem_flush,
  output logic                     cu_cp0_w_en,
  output logic [4:0]               cu_exec_code,
  output logic [31:0]              cu_epc,
  output logic [31:0]              cu_vector,
  output logic                     bpu_write_en,
  output logic [CNT_W-1:0]         perf_bmiss_cnt,
  output logic [CNT_W-1:0]         perf_stall_cnt
);

  localparam logic [3:0] PC_JUMP   = 4'd0;
  localparam logic [3:0] PC_JR     = 4'd1;
  localparam logic [3:0] PC_VECTOR = 4'd2;
  localparam logic [3:0] PC_EPC    = 4'd3;
  localparam logic [3:0] PC_BCORR  = 4'd4;
  localparam logic [3:0] PC_PLUS4  = 4'd5;

  localparam logic [4:0] EXC_INTR    = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;

  // Number of bubbles still owed after the one inserted on the hazard cycle.
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      lu_cnt, lu_cnt_nxt;
  logic            intr_pend, intr_pend_nxt;
  logic            branch_miss;
  logic            load_use;
  logic            intr;
  logic            lu_active;
  logic            bmiss_inc;
  logic            stall_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cu_vector = EXC_VECTOR;

  // Hazard detection
  assign branch_miss = !mem_nop && (predicted_idex_pc != target_exmem_pc);

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < SRC_PORTS; i++) begin
      if (id_src_valid[i] && (id_src_addr[5*i +: 5] == idex_rd_addr)) begin
        load_use = 1'b1;
      end
    end
    // $0 is hard-wired, so a load targeting it never creates a dependency.
    load_use = load_use && idex_mem_read && (idex_rd_addr != 5'd0);
  end

  assign intr      = cp0_intr | intr_pend;
  assign lu_active = (state == LU_WAIT) || load_use;

  // Next-state and control outputs
  always_comb begin
    cu_pc_src      = PC_PLUS4;
    cu_pc_stall    = 1'b0;
    cu_ifid_stall  = 1'b0;
    cu_idex_stall  = 1'b0;
    cu_exmem_stall = 1'b0;
    cu_ifid_flush  = 1'b0;
    cu_idex_flush  = 1'b0;
    cu_exmem_flush = 1'b0;
    cu_cp0_w_en    = 1'b0;
    cu_exec_code   = EXC_INTR;
    cu_epc         = 32'd0;
    bpu_write_en   = 1'b0;
    bmiss_inc      = 1'b0;
    state_nxt      = state;
    lu_cnt_nxt     = lu_cnt;
    // A request that is not serviced this cycle is remembered.
    intr_pend_nxt  = intr_pend | cp0_intr;

    if (!reset) begin
      if (mem_stall) begin
        // Freeze everything; only the interrupt latch may change.
        cu_pc_stall    = 1'b1;
        cu_ifid_stall  = 1'b1;
        cu_idex_stall  = 1'b1;
        cu_exmem_stall = 1'b1;
      end else if (exmem_syscall) begin
        cu_pc_src      = PC_VECTOR;
        cu_ifid_flush  = 1'b1;
        cu_idex_flush  = 1'b1;
        cu_exmem_flush = 1'b1;
        cu_cp0_w_en    = 1'b1;
        cu_exec_code   = EXC_SYSCALL;
        cu_epc         = predicted_idex_pc;
        state_nxt      = RUN;
        lu_cnt_nxt     = 3'd0;
      end else if (intr) begin
        // On a miss the fetched PC is wrong; resume at the resolved target.
        cu_pc_src      = PC_VECTOR;
        cu_ifid_flush  = 1'b1;
        cu_idex_flush  = 1'b1;
        cu_exmem_flush = 1'b1;
        cu_cp0_w_en    = 1'b1;
        cu_exec_code   = EXC_INTR;
        cu_epc         = branch_miss ? target_exmem_pc : predicted_idex_pc;
        bpu_write_en   = branch_miss;
        bmiss_inc      = branch_miss;
        intr_pend_nxt  = 1'b0;
        state_nxt      = RUN;
        lu_cnt_nxt     = 3'd0;
      end else if (branch_miss) begin
        cu_pc_src      = PC_BCORR;
        cu_ifid_flush  = 1'b1;
        cu_idex_flush  = 1'b1;
        cu_exmem_flush = 1'b1;
        bpu_write_en   = 1'b1;
        bmiss_inc      = 1'b1;
        state_nxt      = RUN;
        lu_cnt_nxt     = 3'd0;
      end else if (exmem_eret) begin
        cu_pc_src      = PC_EPC;
        cu_ifid_flush  = 1'b1;
        cu_idex_flush  = 1'b1;
        state_nxt      = RUN;
        lu_cnt_nxt     = 3'd0;
      end else if (lu_active) begin
        // Hold IF and ID, inject a bubble into EX; jumps wait.
        cu_pc_stall    = 1'b1;
        cu_ifid_stall  = 1'b1;
        cu_idex_flush  = 1'b1;
        if (state == RUN) begin
          if (LU_STALL_CYCLES > 1) begin
            state_nxt  = LU_WAIT;
            lu_cnt_nxt = LU_RELOAD;
          end
        end else begin
          lu_cnt_nxt = lu_cnt - 3'd1;
          if (lu_cnt <= 3'd1) begin
            state_nxt  = RUN;
            lu_cnt_nxt = 3'd0;
          end
        end
      end else if (id_jr) begin
        cu_pc_src      = PC_JR;
        cu_ifid_flush  = 1'b1;
      end else if (id_jump) begin
        cu_pc_src      = PC_JUMP;
        cu_ifid_flush  = 1'b1;
      end
    end

    // Memory-stall cycles are frozen, so they are not counted as PC stalls.
    stall_inc = cu_pc_stall && !mem_stall;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      lu_cnt         <= 3'd0;
      intr_pend      <= 1'b0;
      perf_bmiss_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      lu_cnt    <= lu_cnt_nxt;
      intr_pend <= intr_pend_nxt;
      if (bmiss_inc) begin
        perf_bmiss_cnt <= sat_inc(perf_bmiss_cnt);
      end
      if (stall_inc) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
    end
  end

endmodule
